// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access width codes,
// FSM state encoding and exception cause values.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    localparam logic [1:0] CAUSE_LOAD_MISALIGN  = 2'd0;
    localparam logic [1:0] CAUSE_STORE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUS_ERR        = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT        = 2'd3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    // Low two func3 bits give the width; the unused codes fall into word.
    function automatic access_size_t access_size(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment: store lane selects and replicated data, misalignment
// detection, and load shift plus sign/zero extension. Purely combinational.
module lsu_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      sel,
    output logic [XLEN-1:0] wdata_rep,
    output logic            misaligned,
    output logic [XLEN-1:0] load_data
);

    access_size_t    size;
    logic [XLEN-1:0] shifted;

    always_comb begin
        size       = access_size(func3);
        shifted    = rdata >> {off, 3'b000};
        sel        = 4'b1111;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        load_data  = shifted;
        case (size)
            SZ_BYTE: begin
                sel       = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                load_data = func3[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                     : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sel        = 4'b0011 << off;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = off[0];
                load_data  = func3[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                      : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            default: begin
                misaligned = (off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage between EX and WB: issues aligned load/store accesses
// on a strobe/ack bus, stalls upstream while waiting, and reports exceptions.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    input  logic            i_load,
    input  logic            i_store,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_pc,
    input  logic [RD_W-1:0] i_rd,
    input  logic            i_reg_wr,
    input  logic [1:0]      i_result_src,
    output logic            o_ready,
    output logic            o_stb,
    output logic            o_we,
    output logic [XLEN-1:0] o_addr,
    output logic [XLEN-1:0] o_wdata,
    output logic [3:0]      o_sel,
    input  logic            i_ack,
    input  logic            i_err,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_wb_valid,
    output logic [RD_W-1:0] o_wb_rd,
    output logic            o_wb_reg_wr,
    output logic [1:0]      o_wb_result_src,
    output logic [XLEN-1:0] o_wb_result,
    output logic [XLEN-1:0] o_wb_load_data,
    output logic [XLEN-1:0] o_wb_pc4,
    output logic            o_exc_valid,
    output logic [1:0]      o_exc_cause,
    output logic [XLEN-1:0] o_exc_addr,
    output lsu_state_t      dbg_state
);

    if (XLEN != 32) begin : g_xlen_check
        $error("mem_stage_lsu supports XLEN = 32 only");
    end

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      req_func3;

    logic [2:0]      a_func3;
    logic [1:0]      a_off;
    logic [3:0]      a_sel;
    logic [XLEN-1:0] a_wdata;
    logic            a_misaligned;
    logic [XLEN-1:0] a_load_data;
    logic            is_mem;
    logic            timeout_hit;

    // Handshakes: an instruction transfers on a rising edge with i_valid and
    // o_ready both high, and upstream holds its inputs while o_ready is low.
    // A bus access completes on the first rising edge with o_stb and i_ack
    // high; o_stb and its qualifiers stay stable until that edge.
    assign o_ready   = (state != ST_BUS);
    assign dbg_state = state;
    assign is_mem    = i_load | i_store;

    // The latched request address lives in o_wb_result, so its offset feeds
    // load alignment while the access is outstanding.
    assign a_func3 = (state == ST_BUS) ? req_func3 : i_func3;
    assign a_off   = (state == ST_BUS) ? o_wb_result[1:0] : i_addr[1:0];

    assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt) + 1) == TIMEOUT);

    lsu_align #(.XLEN(XLEN)) u_align (
        .func3      (a_func3),
        .off        (a_off),
        .wdata      (i_wdata),
        .rdata      (i_rdata),
        .sel        (a_sel),
        .wdata_rep  (a_wdata),
        .misaligned (a_misaligned),
        .load_data  (a_load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            req_func3       <= '0;
            o_stb           <= 1'b0;
            o_we            <= 1'b0;
            o_addr          <= '0;
            o_wdata         <= '0;
            o_sel           <= '0;
            o_wb_valid      <= 1'b0;
            o_wb_rd         <= '0;
            o_wb_reg_wr     <= 1'b0;
            o_wb_result_src <= '0;
            o_wb_result     <= '0;
            o_wb_load_data  <= '0;
            o_wb_pc4        <= '0;
            o_exc_valid     <= 1'b0;
            o_exc_cause     <= '0;
            o_exc_addr      <= '0;
        end else begin
            o_wb_valid  <= 1'b0;
            o_exc_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    state <= ST_IDLE;
                    if (i_valid) begin
                        o_wb_rd         <= i_rd;
                        o_wb_reg_wr     <= i_reg_wr;
                        o_wb_result_src <= i_result_src;
                        o_wb_result     <= i_addr;
                        o_wb_pc4        <= i_pc + XLEN'(4);
                        req_func3       <= i_func3;
                        if (!is_mem) begin
                            o_wb_valid <= 1'b1;
                        end else if (a_misaligned) begin
                            o_wb_valid  <= 1'b1;
                            o_exc_valid <= 1'b1;
                            o_exc_cause <= i_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                            o_exc_addr  <= i_addr;
                            o_wb_reg_wr <= 1'b0;
                        end else begin
                            state   <= ST_BUS;
                            cnt     <= '0;
                            o_stb   <= 1'b1;
                            o_we    <= i_store;
                            o_addr  <= {i_addr[XLEN-1:2], 2'b00};
                            o_sel   <= i_store ? a_sel : 4'b1111;
                            o_wdata <= a_wdata;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (i_ack) begin
                        o_stb      <= 1'b0;
                        o_wb_valid <= 1'b1;
                        state      <= ST_RESP;
                        if (!o_we) begin
                            o_wb_load_data <= a_load_data;
                        end
                        if (i_err) begin
                            o_exc_valid <= 1'b1;
                            o_exc_cause <= CAUSE_BUS_ERR;
                            o_exc_addr  <= o_wb_result;
                            o_wb_reg_wr <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        o_stb       <= 1'b0;
                        o_wb_valid  <= 1'b1;
                        o_exc_valid <= 1'b1;
                        o_exc_cause <= CAUSE_TIMEOUT;
                        o_exc_addr  <= o_wb_result;
                        o_wb_reg_wr <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a table of load/store/pass-through records
// plus hand-written sequences for reset-in-flight and accept-during-RESP.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_func3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] i_pc;
    logic [4:0]  i_rd;
    logic        i_reg_wr;
    logic [1:0]  i_result_src;
    logic        o_ready;
    logic        o_stb;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_sel;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic        o_wb_reg_wr;
    logic [1:0]  o_wb_result_src;
    logic [31:0] o_wb_result;
    logic [31:0] o_wb_load_data;
    logic [31:0] o_wb_pc4;
    logic        o_exc_valid;
    logic [1:0]  o_exc_cause;
    logic [31:0] o_exc_addr;
    lsu_state_t  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu #(.XLEN(32), .TIMEOUT(15), .RD_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .i_load          (i_load),
        .i_store         (i_store),
        .i_func3         (i_func3),
        .i_addr          (i_addr),
        .i_wdata         (i_wdata),
        .i_pc            (i_pc),
        .i_rd            (i_rd),
        .i_reg_wr        (i_reg_wr),
        .i_result_src    (i_result_src),
        .o_ready         (o_ready),
        .o_stb           (o_stb),
        .o_we            (o_we),
        .o_addr          (o_addr),
        .o_wdata         (o_wdata),
        .o_sel           (o_sel),
        .i_ack           (i_ack),
        .i_err           (i_err),
        .i_rdata         (i_rdata),
        .o_wb_valid      (o_wb_valid),
        .o_wb_rd         (o_wb_rd),
        .o_wb_reg_wr     (o_wb_reg_wr),
        .o_wb_result_src (o_wb_result_src),
        .o_wb_result     (o_wb_result),
        .o_wb_load_data  (o_wb_load_data),
        .o_wb_pc4        (o_wb_pc4),
        .o_exc_valid     (o_exc_valid),
        .o_exc_cause     (o_exc_cause),
        .o_exc_addr      (o_exc_addr),
        .dbg_state       (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        load;
        logic        store;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        reg_wr;
        logic [4:0]  ack_at;     // stb cycle that carries the ack, 0 = never
        logic        err;
        logic [4:0]  exp_stb;
        logic [3:0]  exp_sel;
        logic [31:0] exp_baddr;
        logic [31:0] exp_wdata;
        logic        exp_exc;
        logic [1:0]  exp_cause;
        logic        exp_reg_wr;
        logic        chk_ld;
        logic [31:0] exp_ld;
        logic [31:0] exp_pc4;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_func3 = 3'b0;
        i_addr = 32'h0; i_wdata = 32'h0; i_pc = 32'h0; i_rd = 5'd0;
        i_reg_wr = 1'b0; i_result_src = 2'd0;
        i_ack = 1'b0; i_err = 1'b0; i_rdata = 32'h0;
    endtask

    // Driver: present one instruction at a negedge, serve the bus, check WB.
    task automatic run_vec(input int idx, input vec_t v);
        int         n;
        logic [4:0] rd;
        logic [1:0] src;
        rd  = 5'(idx + 1);
        src = 2'(idx);
        check($sformatf("v%0d ready_before", idx), 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_load = v.load; i_store = v.store; i_func3 = v.func3;
        i_addr = v.addr; i_wdata = v.wdata; i_pc = v.pc; i_rd = rd;
        i_reg_wr = v.reg_wr; i_result_src = src;
        @(negedge clk);
        i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
        n = 0;
        while (o_stb && n < 40) begin
            n++;
            check($sformatf("v%0d ready_bus", idx), 32'(o_ready), 32'd0);
            check($sformatf("v%0d state_bus", idx), 32'(dbg_state), 32'(ST_BUS));
            check($sformatf("v%0d we", idx), 32'(o_we), 32'(v.store));
            check($sformatf("v%0d bus_addr", idx), o_addr, v.exp_baddr);
            check($sformatf("v%0d sel", idx), 32'(o_sel), 32'(v.exp_sel));
            if (v.store) check($sformatf("v%0d wdata", idx), o_wdata, v.exp_wdata);
            check($sformatf("v%0d wb_during_bus", idx), 32'(o_wb_valid), 32'd0);
            if (v.ack_at != 5'd0 && n == int'(v.ack_at)) begin
                i_ack = 1'b1; i_err = v.err; i_rdata = v.rdata;
            end
            @(negedge clk);
            i_ack = 1'b0; i_err = 1'b0; i_rdata = 32'h0;
        end
        check($sformatf("v%0d stb_cycles", idx), 32'(n), 32'(v.exp_stb));
        check($sformatf("v%0d wb_valid", idx), 32'(o_wb_valid), 32'd1);
        check($sformatf("v%0d ready_wb", idx), 32'(o_ready), 32'd1);
        check($sformatf("v%0d stb_off", idx), 32'(o_stb), 32'd0);
        check($sformatf("v%0d exc_valid", idx), 32'(o_exc_valid), 32'(v.exp_exc));
        if (v.exp_exc) begin
            check($sformatf("v%0d exc_cause", idx), 32'(o_exc_cause), 32'(v.exp_cause));
            check($sformatf("v%0d exc_addr", idx), o_exc_addr, v.addr);
        end
        check($sformatf("v%0d wb_reg_wr", idx), 32'(o_wb_reg_wr), 32'(v.exp_reg_wr));
        check($sformatf("v%0d wb_rd", idx), 32'(o_wb_rd), 32'(rd));
        check($sformatf("v%0d wb_src", idx), 32'(o_wb_result_src), 32'(src));
        check($sformatf("v%0d wb_result", idx), o_wb_result, v.addr);
        check($sformatf("v%0d wb_pc4", idx), o_wb_pc4, v.exp_pc4);
        if (v.chk_ld) check($sformatf("v%0d load_data", idx), o_wb_load_data, v.exp_ld);
        @(negedge clk);
        check($sformatf("v%0d wb_pulse", idx), 32'(o_wb_valid), 32'd0);
        check($sformatf("v%0d exc_pulse", idx), 32'(o_exc_valid), 32'd0);
    endtask

    initial begin
        // load,store,func3,addr,wdata,rdata,pc,reg_wr,ack_at,err,exp_stb,exp_sel,exp_baddr,exp_wdata,exp_exc,exp_cause,exp_reg_wr,chk_ld,exp_ld,exp_pc4
        vecs[0]  = '{1'b0, 1'b1, F3_SW,   32'h100, 32'hDEADBEEF, 32'h0,        32'h1000, 1'b0, 5'd3,  1'b0, 5'd3,  4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h1004};
        vecs[1]  = '{1'b1, 1'b0, F3_LB,   32'h203, 32'h0,        32'h80FF1234, 32'h1004, 1'b1, 5'd1,  1'b0, 5'd1,  4'hF, 32'h200, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'hFFFFFF80, 32'h1008};
        vecs[2]  = '{1'b1, 1'b0, F3_LBU,  32'h203, 32'h0,        32'h80FF1234, 32'h1008, 1'b1, 5'd1,  1'b0, 5'd1,  4'hF, 32'h200, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'h00000080, 32'h100C};
        vecs[3]  = '{1'b1, 1'b0, F3_LHU,  32'h202, 32'h0,        32'h80FF1234, 32'h100C, 1'b1, 5'd1,  1'b0, 5'd1,  4'hF, 32'h200, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'h000080FF, 32'h1010};
        vecs[4]  = '{1'b1, 1'b0, F3_LH,   32'h202, 32'h0,        32'h80FF1234, 32'h1010, 1'b1, 5'd1,  1'b0, 5'd1,  4'hF, 32'h200, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'hFFFF80FF, 32'h1014};
        vecs[5]  = '{1'b1, 1'b0, F3_LW,   32'h200, 32'h0,        32'h80FF1234, 32'h1014, 1'b1, 5'd2,  1'b0, 5'd2,  4'hF, 32'h200, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'h80FF1234, 32'h1018};
        vecs[6]  = '{1'b0, 1'b1, F3_SH,   32'h00A, 32'h0000ABCD, 32'h0,        32'h1018, 1'b0, 5'd1,  1'b0, 5'd1,  4'hC, 32'h008, 32'hABCDABCD, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h101C};
        vecs[7]  = '{1'b0, 1'b1, F3_SB,   32'h101, 32'h12345678, 32'h0,        32'h101C, 1'b0, 5'd1,  1'b0, 5'd1,  4'h2, 32'h100, 32'h78787878, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h1020};
        vecs[8]  = '{1'b1, 1'b0, F3_LW,   32'h105, 32'h0,        32'h0,        32'h1020, 1'b1, 5'd0,  1'b0, 5'd0,  4'hF, 32'h0,   32'h0,        1'b1, 2'd0, 1'b0, 1'b0, 32'h0,        32'h1024};
        vecs[9]  = '{1'b0, 1'b1, F3_SH,   32'h203, 32'h0000ABCD, 32'h0,        32'h1024, 1'b0, 5'd0,  1'b0, 5'd0,  4'hF, 32'h0,   32'h0,        1'b1, 2'd1, 1'b0, 1'b0, 32'h0,        32'h1028};
        vecs[10] = '{1'b1, 1'b0, F3_LH,   32'h201, 32'h0,        32'h0,        32'h1028, 1'b1, 5'd0,  1'b0, 5'd0,  4'hF, 32'h0,   32'h0,        1'b1, 2'd0, 1'b0, 1'b0, 32'h0,        32'h102C};
        vecs[11] = '{1'b1, 1'b0, F3_LB,   32'h201, 32'h0,        32'h80FF1234, 32'h102C, 1'b1, 5'd1,  1'b0, 5'd1,  4'hF, 32'h200, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'h00000012, 32'h1030};
        vecs[12] = '{1'b0, 1'b0, 3'b000,  32'h12345678, 32'h0,   32'h0,        32'hFFFFFFFC, 1'b1, 5'd0, 1'b0, 5'd0, 4'hF, 32'h0,  32'h0,        1'b0, 2'd0, 1'b1, 1'b0, 32'h0,        32'h00000000};
        vecs[13] = '{1'b1, 1'b0, 3'b011,  32'h204, 32'h0,        32'hCAFEF00D, 32'h1030, 1'b1, 5'd1,  1'b0, 5'd1,  4'hF, 32'h204, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'hCAFEF00D, 32'h1034};
        vecs[14] = '{1'b1, 1'b0, 3'b011,  32'h206, 32'h0,        32'h0,        32'h1034, 1'b1, 5'd0,  1'b0, 5'd0,  4'hF, 32'h0,   32'h0,        1'b1, 2'd0, 1'b0, 1'b0, 32'h0,        32'h1038};
        vecs[15] = '{1'b1, 1'b0, F3_LW,   32'h300, 32'h0,        32'h55555555, 32'h1038, 1'b1, 5'd2,  1'b1, 5'd2,  4'hF, 32'h300, 32'h0,        1'b1, 2'd2, 1'b0, 1'b0, 32'h0,        32'h103C};
        vecs[16] = '{1'b1, 1'b0, F3_LW,   32'h304, 32'h0,        32'h0,        32'h103C, 1'b1, 5'd0,  1'b0, 5'd15, 4'hF, 32'h304, 32'h0,        1'b1, 2'd3, 1'b0, 1'b0, 32'h0,        32'h1040};
        vecs[17] = '{1'b1, 1'b0, F3_LW,   32'h308, 32'h0,        32'h11223344, 32'h1040, 1'b1, 5'd15, 1'b0, 5'd15, 4'hF, 32'h308, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'h11223344, 32'h1044};
        vecs[18] = '{1'b1, 1'b0, F3_LHU,  32'h206, 32'h0,        32'hBEEF0000, 32'h1044, 1'b1, 5'd1,  1'b0, 5'd1,  4'hF, 32'h204, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'h0000BEEF, 32'h1048};
        vecs[19] = '{1'b1, 1'b0, F3_LH,   32'h206, 32'h0,        32'hBEEF0000, 32'h1048, 1'b1, 5'd1,  1'b0, 5'd1,  4'hF, 32'h204, 32'h0,        1'b0, 2'd0, 1'b1, 1'b1, 32'hFFFFBEEF, 32'h104C};

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst stb", 32'(o_stb), 32'd0);
        check("rst we", 32'(o_we), 32'd0);
        check("rst addr", o_addr, 32'h0);
        check("rst sel", 32'(o_sel), 32'd0);
        check("rst wb_valid", 32'(o_wb_valid), 32'd0);
        check("rst exc_valid", 32'(o_exc_valid), 32'd0);
        check("rst wb_pc4", o_wb_pc4, 32'h0);
        check("rst load_data", o_wb_load_data, 32'h0);
        check("rst ready", 32'(o_ready), 32'd1);
        check("rst state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while a load is outstanding, then a late ack
        i_valid = 1'b1; i_load = 1'b1; i_func3 = F3_LW; i_addr = 32'h400;
        i_pc = 32'h2000; i_rd = 5'd9; i_reg_wr = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("rstbus stb1", 32'(o_stb), 32'd1);
        @(negedge clk);
        check("rstbus stb2", 32'(o_stb), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstbus stb_after", 32'(o_stb), 32'd0);
        check("rstbus ready_after", 32'(o_ready), 32'd1);
        i_ack = 1'b1; i_err = 1'b1; i_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        i_ack = 1'b0; i_err = 1'b0; i_rdata = 32'h0;
        check("late_ack wb_valid", 32'(o_wb_valid), 32'd0);
        check("late_ack exc_valid", 32'(o_exc_valid), 32'd0);
        @(negedge clk);
        check("late_ack wb_valid2", 32'(o_wb_valid), 32'd0);
        check("late_ack stb", 32'(o_stb), 32'd0);

        // New instruction accepted in the RESP cycle
        i_valid = 1'b1; i_load = 1'b1; i_func3 = F3_LW; i_addr = 32'h500;
        i_pc = 32'h2100; i_rd = 5'd3; i_reg_wr = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("resp_acc stb", 32'(o_stb), 32'd1);
        i_ack = 1'b1; i_rdata = 32'h00000055;
        @(negedge clk);
        i_ack = 1'b0; i_rdata = 32'h0;
        check("resp_acc wb_valid", 32'(o_wb_valid), 32'd1);
        check("resp_acc load_data", o_wb_load_data, 32'h00000055);
        check("resp_acc ready", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_addr = 32'h00000ABC; i_pc = 32'h3000; i_rd = 5'd4; i_reg_wr = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("resp_acc pass_valid", 32'(o_wb_valid), 32'd1);
        check("resp_acc pass_pc4", o_wb_pc4, 32'h3004);
        check("resp_acc pass_result", o_wb_result, 32'h00000ABC);
        check("resp_acc pass_rd", 32'(o_wb_rd), 32'd4);
        check("resp_acc pass_stb", 32'(o_stb), 32'd0);
        @(negedge clk);
        check("resp_acc pulse", 32'(o_wb_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the current memory pipeline stage.
- Sits between EX and WB. Issues load/store transactions on a registered strobe/ack data-bus and stalls upstream until the access completes.
- New capabilities: byte-lane stores with write selects, sub-word load alignment by address offset, and misalignment detection.
- Also adds bus-error/timeout exceptions and a single-cycle pass-through for non-memory instructions.

Parameters:
- XLEN, 32, data and address width; only 32 is supported, other values rejected by elaboration check.
- TIMEOUT, 15, maximum bus-wait cycles before a timeout exception; 0 disables the timeout.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  EX-stage instruction valid.
- i_load  in  1  instruction is a load.
- i_store  in  1  instruction is a store.
- i_func3  in  3  load/store width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  XLEN  effective address; equals the ALU result for non-memory ops.
- i_wdata  in  XLEN  store data (rs2).
- i_pc  in  XLEN  instruction PC.
- i_rd  in  RD_W  destination register.
- i_reg_wr  in  1  register write enable.
- i_result_src  in  2  WB mux select, passed through.
- o_ready  out  1  stage can accept; upstream holds inputs while low.
- o_stb  out  1  bus request; held until ack.
- o_we  out  1  bus write.
- o_addr  out  XLEN  word-aligned address (addr[1:0]=00).
- o_wdata  out  XLEN  lane-replicated store data.
- o_sel  out  4  byte-lane enables.
- i_ack  in  1  bus completion.
- i_err  in  1  bus error; valid only with i_ack.
- i_rdata  in  XLEN  read data; valid with i_ack.
- o_wb_valid  out  1  WB outputs valid this cycle.
- o_wb_rd  out  RD_W  destination register.
- o_wb_reg_wr  out  1  register write; forced 0 on exception.
- o_wb_result_src  out  2  passed-through WB select.
- o_wb_result  out  XLEN  ALU result (i_addr).
- o_wb_load_data  out  XLEN  aligned and extended load data.
- o_wb_pc4  out  XLEN  PC+4.
- o_exc_valid  out  1  exception pulse, coincident with o_wb_valid.
- o_exc_cause  out  2  0 load-misaligned, 1 store-misaligned, 2 bus-error, 3 timeout.
- o_exc_addr  out  XLEN  faulting unaligned address.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, timeout counter 0, all registered outputs 0, o_ready=1 from the following cycle.
- FSM has three states: IDLE, BUS, RESP.
- IDLE, o_ready=1:
  - On i_valid with neither load nor store: capture the WB fields; o_wb_valid=1 the next cycle (latency 1).
  - On i_valid with a load or store, aligned: latch the request, go to BUS, o_stb=1 from the next cycle.
  - On i_valid with a load or store, misaligned (H with addr[0]=1, W with addr[1:0]≠0): no bus access; next cycle o_wb_valid=1, o_exc_valid=1, cause 0 or 1, o_wb_reg_wr=0.
- BUS, o_ready=0:
  - o_stb/o_we/o_addr/o_sel/o_wdata are registered and stable until the ack cycle.
  - On i_ack: o_stb drops next edge, go to RESP.
  - Counter increments each BUS cycle without ack. When it reaches TIMEOUT: drop o_stb, exception cause 3, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - i_err together with i_ack gives cause 2.
- RESP: o_wb_valid=1 for one cycle, o_ready=1 in this cycle, then IDLE. Load-to-WB latency is 2 cycles with zero-wait ack.
- Store select and data:
  - SB: o_sel = 0001<<off, o_wdata = byte replicated ×4.
  - SH: o_sel = 0011<<off, o_wdata = half replicated ×2.
  - SW: o_sel = 1111, o_wdata = i_wdata.
  - Loads drive o_sel=1111.
- Load data: shift i_rdata right by off×8, then sign-extend (B/H) or zero-extend (BU/HU); W passes through.
- i_ack while not in BUS is ignored.
- Reset while in BUS: o_stb deasserts after the reset edge; a late ack is ignored.
- o_wb_pc4 = i_pc + 4, modulo 2^XLEN (wraps from 0xFFFFFFFC to 0).
- Undefined func3 on a load is treated as W.

Decomposition:
- Shared package/header holds:
  - func3 codes: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encodings.
  - exception cause constants.
- One sub-module, lsu_align: purely combinational. It generates o_sel and the replicated o_wdata, computes the misaligned flag, and does load shift/extend. Reused by a future cache.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack after 3 cycles → o_stb high 3 cycles, o_sel=1111, o_addr=0x100, o_we=1; o_wb_valid 1 cycle after ack; o_ready low throughout BUS.
- LB addr 0x203, rdata 0x80FF1234 zero-wait → o_addr=0x200, o_wb_load_data=0xFFFFFF80; LBU gives 0x00000080; LHU at 0x202 gives 0x000080FF.
- SH addr 0x0A, data 0x0000ABCD → o_sel=1100, o_wdata=0xABCDABCD.
- LW addr 0x105 → no o_stb, next cycle o_exc_valid=1, cause 0, o_exc_addr=0x105, o_wb_reg_wr=0.
- Load with no ack, TIMEOUT=15 → after 15 BUS cycles o_stb=0, cause 3. Ack with i_err=1 → cause 2. Ack in the same cycle as timeout → normal completion.
- rst_n low during BUS → o_stb=0 after the edge; a subsequent ack produces no o_wb_valid; ADD passthrough with pc 0xFFFFFFFC → o_wb_pc4=0x0, latency 1.
